// File: rtl/rtc_bus_responder_if.sv
// Strobe side of the multiplexed RTC bus, plus visibility of the responder's
// io_port output enable so the far end can see when the responder owns the bus.
interface rtc_bus_responder_if;
    // Handshake: A_D/RD/WR/CS are driven by the master, and RD/WR/CS are active low.
    // There is no ready. The master holds every level for at least 4 clk cycles.
    // The slave acts only on synchronized edges and raises drive_en while it drives io_port.
    logic A_D;
    logic RD;
    logic WR;
    logic CS;
    logic drive_en;

    modport master (output A_D, RD, WR, CS, input drive_en);
    modport slave  (input A_D, RD, WR, CS, output drive_en);
endinterface

// File: rtl/rtc_bus_responder.sv
// RTC chip stand-in: BCD time/date/countdown register file behind a multiplexed
// address/data bus. Strobes and data are resynchronized, and actions fire on synced edges.
module rtc_bus_responder #(
    parameter int CLK_PER_SEC = 100_000_000
) (
    input  logic               clk,
    input  logic               reset,
    rtc_bus_responder_if.slave bus,
    inout  wire  [7:0]         io_port,
    output logic               irq_timer
);
    localparam int PW = $clog2(CLK_PER_SEC);

    logic [1:0]    a_d_sync, rd_sync, wr_sync, cs_sync;
    logic [7:0]    io_sync1, io_sync2;
    logic          wr_prev;
    logic [PW-1:0] presc;
    logic [7:0]    addr;
    logic [7:0]    seg, min, hora, dia, mes, ano;
    logic [7:0]    seg_t, min_t, hora_t;
    logic          timer_en;
    logic [7:0]    rd_data;
    logic          drive_q;

    logic a_d_s, rd_s, wr_s, cs_s;
    logic wr_rise, rd_active, tick;

    assign a_d_s     = a_d_sync[1];
    assign rd_s      = rd_sync[1];
    assign wr_s      = wr_sync[1];
    assign cs_s      = cs_sync[1];
    assign wr_rise   = wr_s && !wr_prev;
    assign rd_active = !cs_s && !rd_s && a_d_s;
    assign tick      = (presc == PW'(CLK_PER_SEC - 1));

    assign io_port      = drive_q ? rd_data : 8'hzz;
    assign bus.drive_en = drive_q;

    // A field wraps when it is at/above its maximum or holds a non-decimal nibble.
    function automatic logic wraps(input logic [7:0] v, input logic [7:0] hi);
        return (v >= hi) || (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lo,
                                           input logic [7:0] hi);
        if (wraps(v, hi)) return lo;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v == 8'h00) return 8'h59;
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    // Leap test: (10*hi + lo) mod 4 == (2*hi + lo) mod 4.
    logic [1:0] leap_sum;
    logic [7:0] dia_max;
    always_comb begin
        leap_sum = {ano[4], 1'b0} + ano[1:0];
        case (mes)
            8'h04, 8'h06, 8'h09, 8'h11: dia_max = 8'h30;
            8'h02:                      dia_max = (leap_sum == 2'b00) ? 8'h29 : 8'h28;
            default:                    dia_max = 8'h31;
        endcase
    end

    logic c_seg, c_min, c_hora, c_dia, c_mes;
    always_comb begin
        c_seg  = wraps(seg, 8'h59);
        c_min  = c_seg  && wraps(min, 8'h59);
        c_hora = c_min  && wraps(hora, 8'h23);
        c_dia  = c_hora && wraps(dia, dia_max);
        c_mes  = c_dia  && wraps(mes, 8'h12);
    end

    logic       s_borrow, m_borrow, timer_zero, timer_next_zero;
    logic [7:0] seg_t_n, min_t_n, hora_t_n;
    always_comb begin
        s_borrow        = (seg_t == 8'h00);
        m_borrow        = s_borrow && (min_t == 8'h00);
        seg_t_n         = bcd_dec(seg_t);
        min_t_n         = s_borrow ? bcd_dec(min_t) : min_t;
        hora_t_n        = m_borrow ? bcd_dec(hora_t) : hora_t;
        timer_zero      = ({hora_t, min_t, seg_t} == 24'h0);
        timer_next_zero = ({hora_t_n, min_t_n, seg_t_n} == 24'h0);
    end

    logic [7:0] rd_mux;
    always_comb begin
        rd_mux = 8'h00;
        case (addr)
            8'h00: rd_mux = {7'b0, timer_en};
            8'h21: rd_mux = seg;
            8'h22: rd_mux = min;
            8'h23: rd_mux = hora;
            8'h24: rd_mux = dia;
            8'h25: rd_mux = mes;
            8'h26: rd_mux = ano;
            8'h41: rd_mux = seg_t;
            8'h42: rd_mux = min_t;
            8'h43: rd_mux = hora_t;
            default: rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_d_sync  <= 2'b00;
            rd_sync   <= 2'b11;
            wr_sync   <= 2'b11;
            cs_sync   <= 2'b11;
            io_sync1  <= 8'h00;
            io_sync2  <= 8'h00;
            wr_prev   <= 1'b1;
            presc     <= '0;
            addr      <= 8'h00;
            seg       <= 8'h00;
            min       <= 8'h00;
            hora      <= 8'h00;
            dia       <= 8'h01;
            mes       <= 8'h01;
            ano       <= 8'h00;
            seg_t     <= 8'h00;
            min_t     <= 8'h00;
            hora_t    <= 8'h00;
            timer_en  <= 1'b0;
            rd_data   <= 8'h00;
            drive_q   <= 1'b0;
            irq_timer <= 1'b0;
        end else begin
            a_d_sync  <= {a_d_sync[0], bus.A_D};
            rd_sync   <= {rd_sync[0], bus.RD};
            wr_sync   <= {wr_sync[0], bus.WR};
            cs_sync   <= {cs_sync[0], bus.CS};
            io_sync1  <= io_port;
            io_sync2  <= io_sync1;
            wr_prev   <= wr_s;
            irq_timer <= 1'b0;
            presc     <= tick ? '0 : presc + PW'(1);

            if (tick) begin
                seg <= bcd_inc(seg, 8'h00, 8'h59);
                if (c_seg)  min  <= bcd_inc(min, 8'h00, 8'h59);
                if (c_min)  hora <= bcd_inc(hora, 8'h00, 8'h23);
                if (c_hora) dia  <= bcd_inc(dia, 8'h01, dia_max);
                if (c_dia)  mes  <= bcd_inc(mes, 8'h01, 8'h12);
                if (c_mes)  ano  <= bcd_inc(ano, 8'h00, 8'h99);
                if (timer_en) begin
                    if (timer_zero) begin
                        irq_timer <= 1'b1;
                        timer_en  <= 1'b0;
                    end else begin
                        seg_t  <= seg_t_n;
                        min_t  <= min_t_n;
                        hora_t <= hora_t_n;
                        if (timer_next_zero) begin
                            irq_timer <= 1'b1;
                            timer_en  <= 1'b0;
                        end
                    end
                end
            end

            // Placed after the tick update so a coincident write wins on its register.
            if (wr_rise && !cs_s) begin
                if (!a_d_s) begin
                    addr <= io_sync2;
                end else begin
                    case (addr)
                        8'h00: timer_en <= io_sync2[0];
                        8'h21: seg      <= io_sync2;
                        8'h22: min      <= io_sync2;
                        8'h23: hora     <= io_sync2;
                        8'h24: dia      <= io_sync2;
                        8'h25: mes      <= io_sync2;
                        8'h26: ano      <= io_sync2;
                        8'h41: seg_t    <= io_sync2;
                        8'h42: min_t    <= io_sync2;
                        8'h43: hora_t   <= io_sync2;
                        default: ;
                    endcase
                end
            end

            // Snapshot on the first active cycle, then hold while the read lasts.
            if (rd_active) begin
                if (!drive_q) rd_data <= rd_mux;
                drive_q <= 1'b1;
            end else begin
                drive_q <= 1'b0;
            end
        end
    end
endmodule
